// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: rename map table, circular free list, busy table and NUM_CKPTS branch checkpoints (RENAME_WB_BYPASS_EN: same-cycle wb clears out_*_busy).
// Latency: 1 cycle from accept to out_*; mispredict restores map and free-list head in 1 cycle.
// Backpressure: ren_ready low when free list empty, all checkpoints live, or mispredict this cycle; outputs never stall.
module rename_map_ckpt #(
    parameter  int NUM_ARCH_REGS = 32,
    parameter  int NUM_PHYS_REGS = 64,
    parameter  int NUM_CKPTS     = 4,
    localparam int ARCH_W        = $clog2(NUM_ARCH_REGS),
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS),
    localparam int CK_W          = $clog2(NUM_CKPTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ren_valid,
    output logic              ren_ready,
    input  logic [ARCH_W-1:0] ren_rs,
    input  logic [ARCH_W-1:0] ren_rt,
    input  logic [ARCH_W-1:0] ren_rw,
    input  logic              ren_uses_rw,
    input  logic              ren_is_branch,
    output logic              out_valid,
    output logic [PREG_W-1:0] out_rs_phys,
    output logic [PREG_W-1:0] out_rt_phys,
    output logic [PREG_W-1:0] out_rw_phys,
    output logic [PREG_W-1:0] out_old_phys,
    output logic              out_rs_busy,
    output logic              out_rt_busy,
    output logic [CK_W-1:0]   out_ckpt_id,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_phys,
    input  logic              commit_valid,
    input  logic              commit_free,
    input  logic [PREG_W-1:0] commit_old_phys,
    input  logic              br_valid,
    input  logic              br_mispredict,
    input  logic [CK_W-1:0]   br_ckpt_id,
    output logic [PREG_W:0]   free_count
);

    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FL_SLOTS = 1 << PREG_W;

    // Pointer MSB is the wrap bit; low bits index 0..FL_DEPTH-1.
    typedef logic [PREG_W:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p[PREG_W-1:0] == PREG_W'(FL_DEPTH - 1)) r = {~p[PREG_W], {PREG_W{1'b0}}};
        else                                        r = p + ptr_t'(1);
        return r;
    endfunction

    function automatic logic [PREG_W:0] ptr_diff(input ptr_t t, input ptr_t h);
        logic [PREG_W:0] ti, hi, r;
        ti = {1'b0, t[PREG_W-1:0]};
        hi = {1'b0, h[PREG_W-1:0]};
        if (t[PREG_W] == h[PREG_W]) r = ti - hi;
        else                        r = ti + (PREG_W+1)'(FL_DEPTH) - hi;
        return r;
    endfunction

    logic [PREG_W-1:0]      rmt_q [NUM_ARCH_REGS];
    logic [PREG_W-1:0]      rmt_d [NUM_ARCH_REGS];
    logic [PREG_W-1:0]      fl_q  [FL_SLOTS];
    logic [PREG_W-1:0]      fl_d  [FL_SLOTS];
    ptr_t                   head_q, head_d, tail_q, tail_d;
    logic [PREG_W:0]        count_q, count_d;
    logic [NUM_PHYS_REGS-1:0] busy_q, busy_d;
    logic [PREG_W-1:0]      ckpt_rmt_q [NUM_CKPTS][NUM_ARCH_REGS];
    logic [PREG_W-1:0]      ckpt_rmt_d [NUM_CKPTS][NUM_ARCH_REGS];
    ptr_t                   ckpt_head_q [NUM_CKPTS];
    ptr_t                   ckpt_head_d [NUM_CKPTS];
    logic [CK_W-1:0]        ck_alloc_q, ck_alloc_d;
    logic [CK_W:0]          live_q, live_d;

    logic                   out_valid_q, out_valid_d;
    logic [PREG_W-1:0]      out_rs_phys_q, out_rs_phys_d, out_rt_phys_q, out_rt_phys_d;
    logic [PREG_W-1:0]      out_rw_phys_q, out_rw_phys_d, out_old_phys_q, out_old_phys_d;
    logic                   out_rs_busy_q, out_rs_busy_d, out_rt_busy_q, out_rt_busy_d;
    logic [CK_W-1:0]        out_ckpt_id_q, out_ckpt_id_d;

    logic                   mispredict, accept, do_alloc, push;
    logic [PREG_W-1:0]      rs_phys, rt_phys, new_phys;
    logic                   rs_busy, rt_busy;

    always_comb begin
        mispredict = br_valid && br_mispredict;
        ren_ready  = (count_q != '0) && (live_q < (CK_W+1)'(NUM_CKPTS)) && !mispredict;
        accept     = ren_valid && ren_ready;
        do_alloc   = accept && ren_uses_rw && (ren_rw != '0);
        push       = commit_valid && commit_free;

        rs_phys  = (ren_rs == '0) ? '0 : rmt_q[ren_rs];
        rt_phys  = (ren_rt == '0) ? '0 : rmt_q[ren_rt];
        new_phys = fl_q[head_q[PREG_W-1:0]];
`ifdef RENAME_WB_BYPASS_EN
        rs_busy = busy_q[rs_phys] && !(wb_valid && wb_phys == rs_phys) && (ren_rs != '0);
        rt_busy = busy_q[rt_phys] && !(wb_valid && wb_phys == rt_phys) && (ren_rt != '0);
`else
        rs_busy = busy_q[rs_phys] && (ren_rs != '0);
        rt_busy = busy_q[rt_phys] && (ren_rt != '0);
`endif

        rmt_d       = rmt_q;
        fl_d        = fl_q;
        head_d      = head_q;
        tail_d      = tail_q;
        busy_d      = busy_q;
        ckpt_rmt_d  = ckpt_rmt_q;
        ckpt_head_d = ckpt_head_q;
        ck_alloc_d  = ck_alloc_q;
        live_d      = live_q;
        count_d     = count_q + (PREG_W+1)'(push) - (PREG_W+1)'(do_alloc);

        out_valid_d    = accept;
        out_rs_phys_d  = '0;
        out_rt_phys_d  = '0;
        out_rw_phys_d  = '0;
        out_old_phys_d = '0;
        out_rs_busy_d  = 1'b0;
        out_rt_busy_d  = 1'b0;
        out_ckpt_id_d  = '0;

        if (push) begin
            fl_d[tail_q[PREG_W-1:0]] = commit_old_phys;
            tail_d = ptr_inc(tail_q);
        end
        if (wb_valid) busy_d[wb_phys] = 1'b0;

        if (accept) begin
            out_rs_phys_d = rs_phys;
            out_rt_phys_d = rt_phys;
            out_rs_busy_d = rs_busy;
            out_rt_busy_d = rt_busy;
            if (do_alloc) begin
                rmt_d[ren_rw]    = new_phys;
                busy_d[new_phys] = 1'b1;
                head_d           = ptr_inc(head_q);
                out_rw_phys_d    = new_phys;
                out_old_phys_d   = rmt_q[ren_rw];
            end
            // Snapshot includes this branch's own destination update.
            if (ren_is_branch) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) ckpt_rmt_d[ck_alloc_q][i] = rmt_d[i];
                ckpt_head_d[ck_alloc_q] = head_d;
                out_ckpt_id_d = ck_alloc_q;
                ck_alloc_d    = ck_alloc_q + CK_W'(1);
                live_d        = live_q + (CK_W+1)'(1);
            end
        end

        if (br_valid && !br_mispredict && live_q != '0) live_d = live_d - (CK_W+1)'(1);

        // No rename can be accepted here, so only the commit push moves tail.
        if (mispredict) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rmt_d[i] = ckpt_rmt_q[br_ckpt_id][i];
            head_d     = ckpt_head_q[br_ckpt_id];
            ck_alloc_d = br_ckpt_id + CK_W'(1);
            live_d     = '0;
            count_d    = ptr_diff(tail_d, head_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rmt_q[i] <= PREG_W'(i);
            for (int i = 0; i < FL_SLOTS; i++)
                fl_q[i] <= (i < FL_DEPTH) ? PREG_W'(NUM_ARCH_REGS + i) : '0;
            head_q  <= '0;
            tail_q  <= {1'b1, {PREG_W{1'b0}}};
            count_q <= (PREG_W+1)'(FL_DEPTH);
            busy_q  <= '0;
            for (int c = 0; c < NUM_CKPTS; c++) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++) ckpt_rmt_q[c][i] <= '0;
                ckpt_head_q[c] <= '0;
            end
            ck_alloc_q     <= '0;
            live_q         <= '0;
            out_valid_q    <= 1'b0;
            out_rs_phys_q  <= '0;
            out_rt_phys_q  <= '0;
            out_rw_phys_q  <= '0;
            out_old_phys_q <= '0;
            out_rs_busy_q  <= 1'b0;
            out_rt_busy_q  <= 1'b0;
            out_ckpt_id_q  <= '0;
        end else begin
            rmt_q          <= rmt_d;
            fl_q           <= fl_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ckpt_rmt_q     <= ckpt_rmt_d;
            ckpt_head_q    <= ckpt_head_d;
            ck_alloc_q     <= ck_alloc_d;
            live_q         <= live_d;
            out_valid_q    <= out_valid_d;
            out_rs_phys_q  <= out_rs_phys_d;
            out_rt_phys_q  <= out_rt_phys_d;
            out_rw_phys_q  <= out_rw_phys_d;
            out_old_phys_q <= out_old_phys_d;
            out_rs_busy_q  <= out_rs_busy_d;
            out_rt_busy_q  <= out_rt_busy_d;
            out_ckpt_id_q  <= out_ckpt_id_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs_phys  = out_rs_phys_q;
    assign out_rt_phys  = out_rt_phys_q;
    assign out_rw_phys  = out_rw_phys_q;
    assign out_old_phys = out_old_phys_q;
    assign out_rs_busy  = out_rs_busy_q;
    assign out_rt_busy  = out_rt_busy_q;
    assign out_ckpt_id  = out_ckpt_id_q;
    assign free_count   = count_q;

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt: vector table for single-cycle behaviour, hand sequences for checkpoints, exhaustion and reset.
module tb_rename_map_ckpt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ren_valid, ren_ready, ren_uses_rw, ren_is_branch;
    logic [4:0] ren_rs, ren_rt, ren_rw;
    logic       out_valid, out_rs_busy, out_rt_busy;
    logic [5:0] out_rs_phys, out_rt_phys, out_rw_phys, out_old_phys;
    logic [1:0] out_ckpt_id;
    logic       wb_valid;
    logic [5:0] wb_phys;
    logic       commit_valid, commit_free;
    logic [5:0] commit_old_phys;
    logic       br_valid, br_mispredict;
    logic [1:0] br_ckpt_id;
    logic [6:0] free_count;

`ifdef RENAME_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    rename_map_ckpt dut (
        .clk(clk), .rst_n(rst_n),
        .ren_valid(ren_valid), .ren_ready(ren_ready),
        .ren_rs(ren_rs), .ren_rt(ren_rt), .ren_rw(ren_rw),
        .ren_uses_rw(ren_uses_rw), .ren_is_branch(ren_is_branch),
        .out_valid(out_valid), .out_rs_phys(out_rs_phys), .out_rt_phys(out_rt_phys),
        .out_rw_phys(out_rw_phys), .out_old_phys(out_old_phys),
        .out_rs_busy(out_rs_busy), .out_rt_busy(out_rt_busy), .out_ckpt_id(out_ckpt_id),
        .wb_valid(wb_valid), .wb_phys(wb_phys),
        .commit_valid(commit_valid), .commit_free(commit_free), .commit_old_phys(commit_old_phys),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .br_ckpt_id(br_ckpt_id),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rv;
        logic [4:0] rs, rt, rw;
        logic       uses;
        logic       wbv;
        logic [5:0] wbp;
        logic       cv, cf;
        logic [5:0] cop;
        logic       e_vld;
        logic [5:0] e_rs, e_rt, e_rw, e_old;
        logic       e_rsb, e_rtb;
        logic [6:0] e_cnt;
    } vec_t;

    function automatic vec_t v(logic rv, logic [4:0] rs, logic [4:0] rt, logic [4:0] rw, logic uses,
                               logic wbv, logic [5:0] wbp, logic cv, logic cf, logic [5:0] cop,
                               logic e_vld, logic [5:0] e_rs, logic [5:0] e_rt, logic [5:0] e_rw,
                               logic [5:0] e_old, logic e_rsb, logic e_rtb, logic [6:0] e_cnt);
        vec_t t;
        t.rv = rv; t.rs = rs; t.rt = rt; t.rw = rw; t.uses = uses;
        t.wbv = wbv; t.wbp = wbp; t.cv = cv; t.cf = cf; t.cop = cop;
        t.e_vld = e_vld; t.e_rs = e_rs; t.e_rt = e_rt; t.e_rw = e_rw; t.e_old = e_old;
        t.e_rsb = e_rsb; t.e_rtb = e_rtb; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        ren_valid = 0; ren_rs = 0; ren_rt = 0; ren_rw = 0; ren_uses_rw = 0; ren_is_branch = 0;
        wb_valid = 0; wb_phys = 0; commit_valid = 0; commit_free = 0; commit_old_phys = 0;
        br_valid = 0; br_mispredict = 0; br_ckpt_id = 0;
    endtask

    task automatic drive_ren(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                             input logic uses, input logic br);
        ren_valid = 1; ren_rs = rs; ren_rt = rt; ren_rw = rw; ren_uses_rw = uses; ren_is_branch = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [5:0] rsp, input logic [5:0] rtp,
                           input logic [5:0] rwp, input logic [5:0] oldp, input logic rsb, input logic rtb,
                           input logic [1:0] ck, input logic [6:0] cnt);
        chk({tag, "_vld"},  out_valid, vld);
        chk({tag, "_rs"},   out_rs_phys, rsp);
        chk({tag, "_rt"},   out_rt_phys, rtp);
        chk({tag, "_rw"},   out_rw_phys, rwp);
        chk({tag, "_old"},  out_old_phys, oldp);
        chk({tag, "_rsb"},  out_rs_busy, rsb);
        chk({tag, "_rtb"},  out_rt_busy, rtb);
        chk({tag, "_ck"},   out_ckpt_id, ck);
        chk({tag, "_cnt"},  free_count, cnt);
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_out(tag, 0, 0, 0, 0, 0, 0, 0, 0, 32);
        chk({tag, "_ready"}, ren_ready, 1);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vt[11];

    initial begin
        vt[0]  = v(1, 0, 0, 5, 1,  0,  0,  0, 0, 0,  1,  0,  0, 32,  5, 0, 0, 31);
        vt[1]  = v(1, 5, 6, 7, 1,  0,  0,  0, 0, 0,  1, 32,  6, 33,  7, 1, 0, 30);
        vt[2]  = v(1, 7, 5, 5, 1,  0,  0,  0, 0, 0,  1, 33, 32, 34, 32, 1, 1, 29);
        vt[3]  = v(1, 5, 0, 0, 1,  0,  0,  0, 0, 0,  1, 34,  0,  0,  0, 1, 0, 29);
        vt[4]  = v(0, 0, 0, 0, 0,  1, 33,  0, 0, 0,  0,  0,  0,  0,  0, 0, 0, 29);
        vt[5]  = v(1, 7, 3, 3, 0,  0,  0,  0, 0, 0,  1, 33,  3,  0,  0, 0, 0, 29);
        vt[6]  = v(1, 5, 0, 0, 0,  1, 34,  0, 0, 0,  1, 34,  0,  0,  0, !BYP, 0, 29);
        vt[7]  = v(0, 0, 0, 0, 0,  0,  0,  1, 1, 5,  0,  0,  0,  0,  0, 0, 0, 30);
        vt[8]  = v(1, 9, 0, 9, 1,  0,  0,  1, 1, 8,  1,  9,  0, 35,  9, 0, 0, 30);
        vt[9]  = v(0, 0, 0, 0, 0,  0,  0,  1, 0, 7,  0,  0,  0,  0,  0, 0, 0, 30);
        vt[10] = v(1, 9, 5, 0, 0,  0,  0,  0, 0, 0,  1, 35, 34,  0,  0, 1, 0, 30);

        do_reset("rst");

        for (int i = 0; i < 11; i++) begin
            ren_valid = vt[i].rv; ren_rs = vt[i].rs; ren_rt = vt[i].rt; ren_rw = vt[i].rw;
            ren_uses_rw = vt[i].uses; ren_is_branch = 0;
            wb_valid = vt[i].wbv; wb_phys = vt[i].wbp;
            commit_valid = vt[i].cv; commit_free = vt[i].cf; commit_old_phys = vt[i].cop;
            tick();
            chk_out($sformatf("v%0d", i), vt[i].e_vld, vt[i].e_rs, vt[i].e_rt, vt[i].e_rw,
                    vt[i].e_old, vt[i].e_rsb, vt[i].e_rtb, 0, vt[i].e_cnt);
            chk($sformatf("v%0d_ready", i), ren_ready, 1);
        end

        // Checkpoint then mispredict restores map and head.
        do_reset("a_rst");
        drive_ren(0, 0, 0, 0, 1); tick();
        chk_out("a_br", 1, 0, 0, 0, 0, 0, 0, 0, 32);
        drive_ren(0, 0, 3, 1, 0); tick();
        chk_out("a_w3", 1, 0, 0, 32, 3, 0, 0, 0, 31);
        drive_ren(3, 0, 4, 1, 0); tick();
        chk_out("a_w4", 1, 32, 0, 33, 4, 1, 0, 0, 30);
        drive_ren(0, 0, 6, 1, 0);
        br_valid = 1; br_mispredict = 1; br_ckpt_id = 0;
        #1;
        chk("a_mis_ready", ren_ready, 0);
        tick();
        chk("a_mis_vld", out_valid, 0);
        chk("a_mis_cnt", free_count, 32);
        drive_ren(3, 4, 8, 1, 1); tick();
        chk_out("a_post", 1, 3, 4, 32, 8, 0, 0, 1, 31);

        // Fill checkpoints, release oldest, then reset mid-stream.
        for (int k = 0; k < 3; k++) begin
            drive_ren(0, 0, 0, 0, 1); tick();
            chk($sformatf("b_ck%0d", k), out_ckpt_id, (2 + k) % 4);
        end
        chk("b_full_ready", ren_ready, 0);
        drive_ren(0, 0, 0, 0, 0); tick();
        chk("b_full_vld", out_valid, 0);
        br_valid = 1; br_mispredict = 0; br_ckpt_id = 1; tick();
        chk("b_rel_ready", ren_ready, 1);
        drive_ren(0, 0, 0, 0, 1); tick();
        chk("b_reuse_vld", out_valid, 1);
        chk("b_reuse_ck", out_ckpt_id, 1);
        rst_n = 0;
        #1;
        chk_out("b_arst", 0, 0, 0, 0, 0, 0, 0, 0, 32);
        chk("b_arst_ready", ren_ready, 1);
        @(negedge clk);
        rst_n = 1;
        drive_ren(3, 8, 5, 1, 0); tick();
        chk_out("b_map", 1, 3, 8, 32, 5, 0, 0, 0, 31);

        // Exhaust the free list, then refill with one commit across the wrap.
        do_reset("c_rst");
        for (int i = 0; i < 32; i++) begin
            drive_ren(0, 0, 5'((i % 31) + 1), 1, 0); tick();
            chk($sformatf("c_alloc%0d", i), out_rw_phys, 32 + i);
        end
        chk("c_empty_cnt", free_count, 0);
        chk("c_empty_ready", ren_ready, 0);
        drive_ren(0, 0, 2, 1, 0);
        commit_valid = 1; commit_free = 1; commit_old_phys = 5;
        #1;
        chk("c_push_ready", ren_ready, 0);
        tick();
        chk("c_push_vld", out_valid, 0);
        chk("c_push_cnt", free_count, 1);
        chk("c_push_ready2", ren_ready, 1);
        drive_ren(1, 0, 1, 1, 0); tick();
        chk_out("c_wrap", 1, 63, 0, 5, 63, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
